// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates, measures line/frame timing,
// locks onto the incoming sync and probes one pixel. Optional per-frame CRC via VGA_RX_CRC_EN.
module vga_rx_monitor #(
  parameter int unsigned H_TOTAL     = 832,
  parameter int unsigned H_SYNC      = 40,
  parameter int unsigned H_BACK      = 128,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 520,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BACK      = 28,
  parameter int unsigned V_ACTIVE    = 480,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rrggbb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic        active,
  output logic [9:0]  x_px,
  output logic [9:0]  y_px,
  output logic [5:0]  pix,
  output logic [10:0] h_period,
  output logic [9:0]  v_lines,
  output logic        frame_done,
  output logic [5:0]  probe_rgb,
  output logic        probe_valid,
  output logic        err_h,
  output logic        err_v,
  output logic [15:0] frame_crc
);

  localparam logic [10:0] HOff     = 11'(H_SYNC + H_BACK);
  localparam logic [9:0]  VOff     = 10'(V_SYNC + V_BACK);
  localparam logic [10:0] HTimeout = 11'(2 * H_TOTAL);
  localparam int unsigned GoodW    = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {StHunt, StAcquire, StLocked} state_e;

  state_e           state_q, state_d;
  logic [GoodW-1:0] good_q, good_d;

  logic        hsync_q, vsync_q, hs_prev_q, vs_prev_q;
  logic [5:0]  rgb_q;
  logic        hs_a, vs_a, hs_edge, vs_edge;
  logic [10:0] h_q, h_cur, h_meas, x_cur;
  logic [9:0]  line_q, line_cur, v_meas, y_cur;
  logic        h_seen_q, v_seen_q, h_bad_q;
  logic        timeout, h_mis, v_mis, frame_clean, active_d, probe_hit, tracking;

  // Input stage: pins registered once, sync polarity normalised to "active".
  always_ff @(posedge px_clk) begin
    if (reset) begin
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      rgb_q     <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      hsync_q   <= hsync;
      vsync_q   <= vsync;
      rgb_q     <= rrggbb;
      hs_prev_q <= hs_a;
      vs_prev_q <= vs_a;
    end
  end

  assign hs_a    = (hsync_q == SYNC_POL);
  assign vs_a    = (vsync_q == SYNC_POL);
  assign hs_edge = hs_a & ~hs_prev_q;
  assign vs_edge = vs_a & ~vs_prev_q;

  always_comb begin
    h_cur = h_q;
    if (hs_edge) begin
      h_cur = '0;
    end else if (h_q != '1) begin
      h_cur = h_q + 11'd1;
    end
    // A vsync edge without a coincident hsync edge parks the line at -1 so the next line is 0.
    line_cur = line_q;
    if (vs_edge) begin
      line_cur = hs_edge ? '0 : '1;
    end else if (hs_edge) begin
      line_cur = line_q + 10'd1;
    end
  end

  assign h_meas      = h_q + 11'd1;
  assign v_meas      = line_q + 10'd1;
  assign timeout     = ~hs_edge & (h_cur >= HTimeout);
  assign h_mis       = hs_edge & h_seen_q & (h_meas != 11'(H_TOTAL));
  assign v_mis       = vs_edge & v_seen_q & (v_meas != 10'(V_TOTAL));
  assign frame_clean = ~(h_bad_q | h_mis) & (v_meas == 10'(V_TOTAL));
  assign x_cur       = h_cur - HOff;
  assign y_cur       = line_cur - VOff;
  assign active_d    = locked & (x_cur < 11'(H_ACTIVE)) & (y_cur < 10'(V_ACTIVE));
  assign probe_hit   = active_d & (x_cur[9:0] == probe_x) & (y_cur == probe_y);

  // Lock FSM: state register.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q <= StHunt;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Lock FSM: next state.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (timeout) begin
      state_d = StHunt;
      good_d  = '0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (vs_edge) begin
            state_d = StAcquire;
            good_d  = '0;
          end
        end
        StAcquire: begin
          if (vs_edge) begin
            if (frame_clean) begin
              good_d = good_q + GoodW'(1);
              if (good_d == GoodW'(LOCK_FRAMES)) state_d = StLocked;
            end else begin
              good_d = '0;
            end
          end
        end
        StLocked: begin
          if (h_mis | v_mis) begin
            state_d = StAcquire;
            good_d  = '0;
          end
        end
        default: begin
          state_d = StHunt;
          good_d  = '0;
        end
      endcase
    end
  end

  // Lock FSM: outputs.
  always_comb begin
    locked   = (state_q == StLocked);
    tracking = (state_q != StHunt);
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      h_q         <= '0;
      line_q      <= '0;
      h_seen_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      h_bad_q     <= 1'b0;
      h_period    <= '0;
      v_lines     <= '0;
      frame_done  <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      active      <= 1'b0;
      x_px        <= '0;
      y_px        <= '0;
      pix         <= '0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      h_q    <= h_cur;
      line_q <= line_cur;
      if (timeout) begin
        h_seen_q <= 1'b0;
      end else if (hs_edge) begin
        h_seen_q <= 1'b1;
      end
      if (vs_edge) v_seen_q <= 1'b1;
      // Tracks whether the frame in progress has seen a bad line; scored at its vsync.
      h_bad_q <= vs_edge ? 1'b0 : (h_bad_q | h_mis);
      if (hs_edge && h_seen_q) h_period <= h_meas;
      frame_done <= vs_edge & v_seen_q;
      if (vs_edge && v_seen_q) v_lines <= v_meas;
      if (tracking) begin
        err_h <= err_h | h_mis;
        err_v <= err_v | v_mis;
      end
      active <= active_d;
      if (active_d) begin
        x_px <= x_cur[9:0];
        y_px <= y_cur;
        pix  <= rgb_q;
      end
      probe_valid <= probe_hit;
      if (probe_hit) probe_rgb <= rgb_q;
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [5:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 5; i >= 0; i--) begin
      c = (c[15] ^ data[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge px_clk) begin
    if (reset) begin
      crc_q     <= 16'hFFFF;
      frame_crc <= '0;
    end else if (vs_edge) begin
      frame_crc <= crc_q;
      crc_q     <= 16'hFFFF;
    end else if (active_d) begin
      crc_q <= crc_step(crc_q, rgb_q);
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Self-checking bench for vga_rx_monitor: frame-level vector table plus a per-sample
// timestamp-based reference model driven with random pixels and probes.
module tb_vga_rx_monitor;

  localparam int HT = 24, HS = 3, HB = 5, HA = 12;
  localparam int VT = 14, VS = 2, VB = 3, VA = 8;
  localparam int LF = 2;
  localparam bit SP = 1'b0;

  logic        px_clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1;
  logic [5:0]  rrggbb = '0;
  logic [9:0]  probe_x = '0, probe_y = '0;
  logic        locked, active, frame_done, probe_valid, err_h, err_v;
  logic [9:0]  x_px, y_px, v_lines;
  logic [5:0]  pix, probe_rgb;
  logic [10:0] h_period;
  logic [15:0] frame_crc;

  always #5 px_clk = ~px_clk;

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .SYNC_POL(SP), .LOCK_FRAMES(LF)
  ) dut (
    .px_clk(px_clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rrggbb(rrggbb),
    .probe_x(probe_x), .probe_y(probe_y), .locked(locked), .active(active),
    .x_px(x_px), .y_px(y_px), .pix(pix), .h_period(h_period), .v_lines(v_lines),
    .frame_done(frame_done), .probe_rgb(probe_rgb), .probe_valid(probe_valid),
    .err_h(err_h), .err_v(err_v), .frame_crc(frame_crc)
  );

  typedef struct {
    logic        locked, active;
    logic [9:0]  x, y;
    logic [5:0]  pix;
    logic [10:0] hp;
    logic [9:0]  vl;
    logic        fd;
    logic [5:0]  prgb;
    logic        pv, eh, ev;
    logic [15:0] crc;
    int          tag;
  } exp_t;

  typedef struct {
    int   lines, odd_line, delta;
    logic locked, eh, ev;
    int   vl, hp;
  } frame_vec_t;

  frame_vec_t tbl[12];
  exp_t       q[$];
  int total = 0, bad = 0, fd_count = 0, pv_count = 0, pat_mode = 0;

  // Reference model state (timestamps of sync edges rather than counters).
  int   m_s = 0, m_last_hs, m_cnt, m_off, m_mode, m_good;
  logic m_phs, m_pvs, m_hseen, m_vseen, m_dirty;
  logic [15:0] m_acc;
  exp_t m;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
      if (bad > 200) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  function automatic logic [74:0] dut_vec();
    return {locked, active, x_px, y_px, pix, h_period, v_lines, frame_done, probe_rgb,
            probe_valid, err_h, err_v, frame_crc};
  endfunction

  function automatic logic [74:0] exp_vec(input exp_t e);
    return {e.locked, e.active, e.x, e.y, e.pix, e.hp, e.vl, e.fd, e.prgb, e.pv, e.eh, e.ev,
            e.crc};
  endfunction

  function automatic logic [15:0] crc6(input logic [15:0] crc, input logic [5:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
      else c = c << 1;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_phs = 0; m_pvs = 0; m_last_hs = m_s - 1; m_hseen = 0; m_vseen = 0; m_dirty = 0;
    m_cnt = 0; m_off = 0; m_mode = 0; m_good = 0; m_acc = 16'hFFFF;
    m = '{default: 0};
  endtask

  task automatic model_step(input logic hs_act, input logic vs_act, input logic [5:0] rgb,
                            input int tag);
    logic hse, vse, tmo, hmis, vmis, act, clean;
    int per, h, line_b, line_c, x, y, vl;
    hse = hs_act && !m_phs;
    vse = vs_act && !m_pvs;
    per = m_s - m_last_hs;
    h = hse ? 0 : (per > 2047 ? 2047 : per);
    line_b = (m_cnt + m_off) & 1023;
    if (vse) begin m_cnt = 0; m_off = -1; end
    if (hse) m_cnt++;
    line_c = (m_cnt + m_off) & 1023;
    tmo  = !hse && h >= 2 * HT;
    hmis = hse && m_hseen && per != HT;
    vl   = (line_b + 1) & 1023;
    vmis = vse && m_vseen && vl != VT;
    x = h - (HS + HB);
    y = line_c - (VS + VB);
    act = (m_mode == 2) && x >= 0 && x < HA && y >= 0 && y < VA;
    m.fd = vse && m_vseen;
    if (m.fd) m.vl = 10'(vl);
    if (hse && m_hseen) m.hp = 11'((per > 2048 ? 2048 : per) & 2047);
    if (m_mode != 0) begin
      if (hmis) m.eh = 1'b1;
      if (vmis) m.ev = 1'b1;
    end
    m.active = act;
    if (act) begin m.x = 10'(x); m.y = 10'(y); m.pix = rgb; end
    m.pv = act && x == int'(probe_x) && y == int'(probe_y);
    if (m.pv) m.prgb = rgb;
`ifdef VGA_RX_CRC_EN
    if (vse) begin m.crc = m_acc; m_acc = 16'hFFFF; end
    else if (act) m_acc = crc6(m_acc, rgb);
`endif
    clean = !(m_dirty || hmis) && vl == VT;
    if (tmo) begin m_mode = 0; m_good = 0; end
    else if (m_mode == 0) begin if (vse) begin m_mode = 1; m_good = 0; end end
    else if (m_mode == 1) begin
      if (vse) begin
        if (clean) begin m_good++; if (m_good == LF) m_mode = 2; end
        else m_good = 0;
      end
    end else if (hmis || vmis) begin m_mode = 1; m_good = 0; end
    m.locked = (m_mode == 2);
    m_dirty = vse ? 1'b0 : (m_dirty || hmis);
    if (tmo) m_hseen = 0; else if (hse) m_hseen = 1;
    if (vse) m_vseen = 1;
    if (hse) m_last_hs = m_s;
    m_phs = hs_act; m_pvs = vs_act; m_s++;
    m.tag = tag;
    q.push_back(m);
  endtask

  task automatic check_pop();
    exp_t e;
    e = q.pop_front();
    check($sformatf("outputs sample %0d", m_s - 2), 128'(dut_vec()), 128'(exp_vec(e)));
    if (frame_done) fd_count++;
    if (probe_valid) pv_count++;
    if (e.tag >= 0)
      check($sformatf("frame row %0d (fd lk eh ev vl hp)", e.tag),
            128'({frame_done, locked, err_h, err_v, v_lines, h_period}),
            128'({1'b1, tbl[e.tag].locked, tbl[e.tag].eh, tbl[e.tag].ev, 10'(tbl[e.tag].vl),
                  11'(tbl[e.tag].hp)}));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_sample(input logic hs_act, input logic vs_act, input logic [5:0] rgb,
                              input int tag);
    if (q.size() == 2) check_pop();
    hsync  = SP ? hs_act : ~hs_act;
    vsync  = SP ? vs_act : ~vs_act;
    rrggbb = rgb;
    model_step(hs_act, vs_act, rgb, tag);
    @(negedge px_clk);
  endtask

  task automatic send_frame(input int lines, input int odd_line, input int delta, input int tag,
                            input int from, input int upto);
    int n, len;
    logic [5:0] rgb;
    n = 0;
    for (int i = 0; i < lines; i++) begin
      len = HT + ((i == odd_line) ? delta : 0);
      for (int j = 0; j < len; j++) begin
        if (pat_mode == 1) rgb = (j - (HS + HB) == 5 && i - (VS + VB) == 3) ? 6'h15 : 6'h00;
        else rgb = 6'($urandom);
        if (n >= from && n < upto)
          drive_sample(j < HS, i < VS, rgb, (i == 0 && j == 0) ? tag : -1);
        n++;
      end
    end
  endtask

  task automatic normal_frames(input int count);
    for (int k = 0; k < count; k++) send_frame(VT, -1, 0, -1, 0, 1 << 30);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge px_clk);
    check("outputs cleared by reset", 128'(dut_vec()), 128'(0));
    reset = 1'b0;
    q.delete();
    model_reset();
  endtask

  initial begin
    int fd0, pv0, lines, odd, delta;
    //           lines odd dlt lk eh ev vl  hp
    tbl[0]  = '{VT, -1,  0, 0, 0, 0, 14, 24};
    tbl[1]  = '{VT, -1,  0, 1, 0, 0, 14, 24};
    tbl[2]  = '{VT, -1,  0, 1, 0, 0, 14, 24};
    tbl[3]  = '{VT,  5, -1, 0, 1, 0, 14, 24};
    tbl[4]  = '{VT, -1,  0, 0, 1, 0, 14, 24};
    tbl[5]  = '{VT, -1,  0, 1, 1, 0, 14, 24};
    tbl[6]  = '{13, -1,  0, 0, 1, 1, 13, 24};
    tbl[7]  = '{VT, -1,  0, 0, 1, 1, 14, 24};
    tbl[8]  = '{VT, -1,  0, 1, 1, 1, 14, 24};
    tbl[9]  = '{VT, 13,  1, 0, 1, 1, 14, 25};
    tbl[10] = '{VT, -1,  0, 0, 1, 1, 14, 24};
    tbl[11] = '{VT, -1,  0, 1, 1, 1, 14, 24};

    repeat (3) @(negedge px_clk);
    apply_reset();

    // Frame-by-frame vectors; frame k is closed by the edge tagged k.
    for (int k = 0; k < 12; k++) begin
      probe_x = 10'($urandom_range(0, HA + 1));
      probe_y = 10'($urandom_range(0, VA + 1));
      send_frame(tbl[k].lines, tbl[k].odd_line, tbl[k].delta, k - 1, 0, 1 << 30);
    end
    send_frame(VT, -1, 0, 11, 0, 1 << 30);

    // Single lit pixel under the probe: one capture per frame.
    pat_mode = 1; probe_x = 10'd5; probe_y = 10'd3; pv0 = pv_count;
    normal_frames(2);
    check("probe captures per two frames", 128'(pv_count - pv0), 128'(2));
    check("probe colour", 128'(probe_rgb), 128'(6'h15));
    pat_mode = 0;

    // Random pixels, probes and timing disturbances.
    for (int k = 0; k < 10; k++) begin
      probe_x = 10'($urandom_range(0, HA + 1));
      probe_y = 10'($urandom_range(0, VA + 1));
      lines = VT; odd = -1; delta = 0;
      case ($urandom_range(0, 3))
        1: begin odd = $urandom_range(0, VT - 1); delta = $urandom_range(0, 1) ? 1 : -1; end
        2: lines = VT - 1 + 2 * $urandom_range(0, 1);
        default: ;
      endcase
      send_frame(lines, odd, delta, -1, 0, 1 << 30);
    end
    normal_frames(3);
    check("locked before sync loss", 128'(locked), 128'(1));

    // Sync loss: hsync held inactive well past 2*H_TOTAL samples.
    for (int k = 0; k < 2 * HT + 12; k++) drive_sample(1'b0, 1'b0, 6'($urandom), -1);
    check("unlocked after hsync timeout", 128'(locked), 128'(0));
    normal_frames(3);
    check("relocked after sync returns", 128'(locked), 128'(1));

    // Reset mid-frame inside the visible area.
    send_frame(VT, -1, 0, -1, 0, 7 * HT + 12);
    apply_reset();
    fd0 = fd_count;
    send_frame(VT, -1, 0, -1, 7 * HT + 13, 1 << 30);
    normal_frames(1);
    check("no frame_done through first vsync after reset", 128'(fd_count - fd0), 128'(0));
    normal_frames(1);
    check("frame_done at second vsync after reset", 128'(fd_count - fd0), 128'(1));
    check("h_period after reset recovery", 128'(h_period), 128'(HT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
